// File: rtl/row_col_cod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_col_cod_pkg
// Description : Capacitor-bank array geometries shared by row/column coders.
// Revision    : 1.0 - initial release
// ============================================================================
package row_col_cod_pkg;

    localparam int LARGE_ROWS    = 5;
    localparam int LARGE_COLS    = 5;
    localparam int LARGE_WORD_W  = 5;

    localparam int MEDIUM_ROWS   = 16;
    localparam int MEDIUM_COLS   = 16;
    localparam int MEDIUM_WORD_W = 8;

    localparam int SMALL_ROWS    = 16;
    localparam int SMALL_COLS    = 16;
    localparam int SMALL_WORD_W  = 8;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_col_cod_5x5.sv
`default_nettype none
// ============================================================================
// Module      : row_col_cod_5x5
// Description : Large-bank 5x5 row/column coder wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module row_col_cod_5x5
    import row_col_cod_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LARGE_WORD_W-1:0] word,
    output logic [LARGE_ROWS-1:0]   r_all,
    output logic [LARGE_ROWS-1:0]   row,
    output logic [LARGE_COLS-1:0]   col
);

    row_col_cod #(
        .N_ROWS (LARGE_ROWS),
        .N_COLS (LARGE_COLS),
        .WORD_W (LARGE_WORD_W)
    ) u_cod (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .word  (word),
        .r_all (r_all),
        .row   (row),
        .col   (col)
    );

endmodule
`default_nettype wire

// File: rtl/therm_dec.sv
`default_nettype none
// ============================================================================
// Module      : therm_dec
// Description : Index to thermometer decoder; bit j set when j < idx.
// Revision    : 1.0 - initial release
// ============================================================================
module therm_dec #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] therm
);

    generate
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            assign therm[j] = ({{(32-IDX_W){1'b0}}, idx} > 32'(j));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/row_col_cod.sv
`default_nettype none
// ============================================================================
// Module      : row_col_cod
// Description : Binary word to row/column unit-cell select coder, registered.
// Revision    : 1.0 - initial release
// ============================================================================
module row_col_cod
    import row_col_cod_pkg::*;
#(
    parameter int N_ROWS = MEDIUM_ROWS,
    parameter int N_COLS = MEDIUM_COLS,
    parameter int WORD_W = MEDIUM_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    output logic [N_ROWS-1:0] r_all,
    output logic [N_ROWS-1:0] row,
    output logic [N_COLS-1:0] col
);

    localparam int CELLS = N_ROWS * N_COLS;
    localparam int CNT_W = idx_w(CELLS);
    localparam int XW    = ((WORD_W > CNT_W) ? WORD_W : CNT_W) + 1;
    localparam int RI_W  = idx_w(N_ROWS);
    localparam int CI_W  = idx_w(N_COLS);

    logic [XW-1:0]     w_word_x;
    logic [XW-1:0]     w_base;
    logic [RI_W-1:0]   w_ridx;
    logic [CI_W-1:0]   w_cidx;
    logic              w_sat;
    logic [N_ROWS-1:0] w_rall;
    logic [N_ROWS-1:0] w_row;
    logic [N_COLS-1:0] w_col;

    logic [N_ROWS-1:0] r_rall;
    logic [N_ROWS-1:0] r_row;
    logic [N_COLS-1:0] r_col;

    assign w_word_x = XW'(word);
    assign w_sat    = (w_word_x >= XW'(CELLS));

    // Quotient by comparison against constant row boundaries; works for any N_COLS.
    always_comb begin
        w_ridx = '0;
        w_base = '0;
        for (int r = 1; r <= N_ROWS; r++) begin
            if (w_word_x >= XW'(r * N_COLS)) begin
                w_ridx = RI_W'(r);
                w_base = XW'(r * N_COLS);
            end
        end
    end

    assign w_cidx = w_sat ? '0 : CI_W'(w_word_x - w_base);

    always_comb begin
        w_row = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            w_row[i] = (w_ridx == RI_W'(i));
        end
    end

    therm_dec #(
        .WIDTH (N_ROWS),
        .IDX_W (RI_W)
    ) u_rall_dec (
        .idx   (w_ridx),
        .therm (w_rall)
    );

    therm_dec #(
        .WIDTH (N_COLS),
        .IDX_W (CI_W)
    ) u_col_dec (
        .idx   (w_cidx),
        .therm (w_col)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rall <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (en) begin
            r_rall <= w_rall;
            r_row  <= w_row;
            r_col  <= w_col;
        end
    end

    assign r_all = r_rall;
    assign row   = r_row;
    assign col   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_row_col_cod.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_col_cod
// Description : Self-checking bench for row_col_cod (16x16) and the 5x5 wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_col_cod;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0;
    logic [7:0]  word_a = '0;
    logic [15:0] rall_a, row_a, col_a;
    logic        en_b = 1'b0;
    logic [4:0]  word_b = '0;
    logic [4:0]  rall_b, row_b, col_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    row_col_cod #(.N_ROWS(16), .N_COLS(16), .WORD_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .word(word_a),
        .r_all(rall_a), .row(row_a), .col(col_a)
    );

    row_col_cod_5x5 dut_b (
        .clk(clk), .rst(rst), .en(en_b), .word(word_b),
        .r_all(rall_b), .row(row_b), .col(col_b)
    );

    typedef struct {
        logic        en;
        logic [7:0]  word;
        logic [15:0] rall;
        logic [15:0] row;
        logic [15:0] col;
    } vec16_t;

    typedef struct {
        logic [4:0] word;
        logic [4:0] rall;
        logic [4:0] row;
        logic [4:0] col;
    } vec5_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: fill cells in row-major order, then describe the array shape.
    task automatic model(input int nr, input int nc, input int w,
                         output logic [31:0] ra, output logic [31:0] ro, output logic [31:0] co);
        int q, m;
        ra = '0; ro = '0; co = '0;
        if (w >= nr * nc) begin
            for (int i = 0; i < nr; i++) ra[i] = 1'b1;
        end else begin
            q = w / nc;
            m = w % nc;
            for (int i = 0; i < q; i++) ra[i] = 1'b1;
            ro[q] = 1'b1;
            for (int j = 0; j < m; j++) co[j] = 1'b1;
        end
    endtask

    function automatic int cells_on(input int nr, input int nc, input logic [31:0] ra,
                                    input logic [31:0] ro, input logic [31:0] co);
        int c = 0;
        for (int i = 0; i < nr; i++)
            for (int j = 0; j < nc; j++)
                if (ra[i] | (ro[i] & co[j])) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec16_t v16[6];
    vec5_t  v5[5];
    logic [31:0] e_ra, e_ro, e_co;
    logic [31:0] h_ra, h_ro, h_co;
    int          w, lim;

    initial begin
        v16[0] = '{1'b1, 8'd128, 16'h00FF, 16'h0100, 16'h0000};
        v16[1] = '{1'b1, 8'd0,   16'h0000, 16'h0001, 16'h0000};
        v16[2] = '{1'b1, 8'd255, 16'h7FFF, 16'h8000, 16'h7FFF};
        v16[3] = '{1'b1, 8'd128, 16'h00FF, 16'h0100, 16'h0000};
        v16[4] = '{1'b0, 8'd7,   16'h00FF, 16'h0100, 16'h0000};
        v16[5] = '{1'b1, 8'd7,   16'h0000, 16'h0001, 16'h007F};

        v5[0] = '{5'd13, 5'b00011, 5'b00100, 5'b00111};
        v5[1] = '{5'd24, 5'b01111, 5'b10000, 5'b01111};
        v5[2] = '{5'd25, 5'b11111, 5'b00000, 5'b00000};
        v5[3] = '{5'd31, 5'b11111, 5'b00000, 5'b00000};
        v5[4] = '{5'd0,  5'b00000, 5'b00001, 5'b00000};

        // Reset holds outputs at zero even with en high and clocks running.
        en_a = 1'b1; word_a = 8'd200;
        #2;
        chk("reset_rall", 32'(rall_a), 32'h0);
        chk("reset_row",  32'(row_a),  32'h0);
        chk("reset_col",  32'(col_a),  32'h0);
        tick();
        chk("reset_clk_rall", 32'(rall_a), 32'h0);
        rst = 1'b1;
        en_a = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            en_a = v16[k].en; word_a = v16[k].word;
            tick();
            chk($sformatf("v16[%0d]_rall", k), 32'(rall_a), 32'(v16[k].rall));
            chk($sformatf("v16[%0d]_row",  k), 32'(row_a),  32'(v16[k].row));
            chk($sformatf("v16[%0d]_col",  k), 32'(col_a),  32'(v16[k].col));
        end

        en_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            word_b = v5[k].word;
            tick();
            chk($sformatf("v5[%0d]_rall", k), 32'(rall_b), 32'(v5[k].rall));
            chk($sformatf("v5[%0d]_row",  k), 32'(row_b),  32'(v5[k].row));
            chk($sformatf("v5[%0d]_col",  k), 32'(col_b),  32'(v5[k].col));
        end

        // No combinational path: changing word between edges leaves outputs alone.
        en_a = 1'b1; word_a = 8'd128;
        tick();
        word_a = 8'd3;
        #3;
        chk("no_comb_rall", 32'(rall_a), 32'h00FF);

        // Asynchronous reset between edges, then release and reload.
        rst = 1'b0;
        #1;
        chk("async_rst_rall", 32'(rall_a), 32'h0);
        chk("async_rst_row",  32'(row_a),  32'h0);
        chk("async_rst_col",  32'(col_a),  32'h0);
        tick();
        chk("rst_over_en_row", 32'(row_a), 32'h0);
        rst = 1'b1;
        word_a = 8'd33;
        tick();
        chk("post_rst_rall", 32'(rall_a), 32'h0003);
        chk("post_rst_row",  32'(row_a),  32'h0004);
        chk("post_rst_col",  32'(col_a),  32'h0001);

        // Exhaustive sweeps with on-cell count check.
        en_a = 1'b1; en_b = 1'b1;
        for (int k = 0; k < 256; k++) begin
            word_a = 8'(k); word_b = 5'(k);
            tick();
            model(16, 16, k, e_ra, e_ro, e_co);
            chk($sformatf("sweep16_%0d", k), {rall_a, row_a} , {e_ra[15:0], e_ro[15:0]});
            chk($sformatf("sweep16_col_%0d", k), 32'(col_a), e_co);
            chk($sformatf("sweep16_cnt_%0d", k),
                32'(cells_on(16, 16, 32'(rall_a), 32'(row_a), 32'(col_a))), 32'(k));
            if (k < 32) begin
                model(5, 5, k, e_ra, e_ro, e_co);
                chk($sformatf("sweep5_%0d", k), {17'd0, rall_b, row_b, col_b},
                    {17'd0, e_ra[4:0], e_ro[4:0], e_co[4:0]});
                lim = (k < 25) ? k : 25;
                chk($sformatf("sweep5_cnt_%0d", k),
                    32'(cells_on(5, 5, 32'(rall_b), 32'(row_b), 32'(col_b))), 32'(lim));
            end
        end

        // Random en/word against a held-state model.
        model(16, 16, 255, h_ra, h_ro, h_co);
        for (int k = 0; k < 300; k++) begin
            en_a = 1'($urandom_range(0, 1));
            w = int'($urandom_range(0, 255));
            word_a = 8'(w);
            if (en_a) model(16, 16, w, h_ra, h_ro, h_co);
            tick();
            chk($sformatf("rand_%0d_rall", k), 32'(rall_a), h_ra);
            chk($sformatf("rand_%0d_row",  k), 32'(row_a),  h_ro);
            chk($sformatf("rand_%0d_col",  k), 32'(col_a),  h_co);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
